// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite flop-array SRAM with programmable wait states and byte/half-word strobes.
// Define AHB_SRAM_ERR_RESP_EN to answer out-of-range or misaligned transfers with a two-cycle ERROR.
module ahb_sram_slave #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        r_state;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_size;
  logic          r_write;
  logic [3:0]    r_cnt;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_open;
  logic          w_accept;
  logic          w_err;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // Only states that drive HREADYOUT high may take a new address phase.
  assign w_open   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept = HSEL && HREADY && HTRANS[1] && w_open;
  assign w_idx    = r_addr[AW+1:2];
  assign w_unused = ^{HADDR, HTRANS[0]};

`ifdef AHB_SRAM_ERR_RESP_EN
  assign w_err = (HADDR >= (32'(DEPTH_WORDS) << 2)) ||
                 ((HSIZE == 3'd1) && HADDR[0]) ||
                 ((HSIZE >= 3'd2) && (HADDR[1:0] != 2'b00));
  assign HRESP = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
  assign w_err = 1'b0;
  assign HRESP = 1'b0;
`endif

  assign HREADYOUT = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[w_idx] : 32'd0;

  assign w_be = (r_size == 3'd0) ? (4'b0001 << r_addr[1:0]) :
                (r_size == 3'd1) ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= HADDR[AW+1:0];
      r_size  <= HSIZE;
      r_write <= HWRITE;
      r_cnt   <= WS_LOAD;
      r_state <= w_err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_DATA;
    end else begin
      case (r_state)
        S_WAIT:  if (r_cnt == 4'd0) r_state <= S_DATA; else r_cnt <= r_cnt - 4'd1;
        S_ERR1:  r_state <= S_ERR2;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset; a reset drops r_state so no write can commit.
  always_ff @(posedge HCLK) begin
    if (r_state == S_DATA && r_write)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of ahb_sram_slave with zero and three wait states.
// Expectations follow AHB_SRAM_ERR_RESP_EN when it is defined for the build.
module tb_ahb_sram_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel0 = 1'b0;
  logic        sel3 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic        rdy0, rdy3, resp0, resp3;
  logic [31:0] rdata0, rdata3;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pd [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

  always #5 clk = ~clk;

  ahb_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy0), .HREADYOUT(rdy0), .HRDATA(rdata0), .HRESP(resp0));

  ahb_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy3), .HREADYOUT(rdy3), .HRDATA(rdata3), .HRESP(resp3));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single NONSEQ transfer; reports the final data-phase read data, HRESP and the number of low-ready cycles.
  task automatic xfer(input bit w3, input logic [31:0] a, input logic [2:0] sz, input bit wr,
                      input logic [31:0] wd, output logic [31:0] rd, output int lows, output logic rs);
    tick();
    sel0 = !w3; sel3 = w3; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
    tick();
    htrans = 2'b00; hwdata = wd; lows = 0;
    while (((w3 ? rdy3 : rdy0) == 1'b0) && lows < 20) begin
      lows++;
      tick();
    end
    rd = w3 ? rdata3 : rdata0;
    rs = w3 ? resp3 : resp0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_rdy0 got %b want 1", rdy0); end
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL reset_rdy3 got %b want 1", rdy3); end
    checks++; if (resp0 !== 1'b0) begin failures++; $display("FAIL reset_resp0 got %b want 0", resp0); end
    checks++; if (resp3 !== 1'b0) begin failures++; $display("FAIL reset_resp3 got %b want 0", resp3); end
    checks++; if (rdata0 !== 32'd0) begin failures++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
    checks++; if (rdata3 !== 32'd0) begin failures++; $display("FAIL reset_rdata3 got %h want 0", rdata3); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; int lows; logic rs;
    xfer(0, 32'h0, 3'd2, 1, 32'h000D_EEEE, rd, lows, rs);
    checks++; if (lows !== 0 || rs !== 1'b0) begin failures++; $display("FAIL word_wr lows/resp got %0d/%b want 0/0", lows, rs); end
    xfer(0, 32'h0, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'h000D_EEEE) begin failures++; $display("FAIL word_rd got %h want 000deeee", rd); end
    checks++; if (lows !== 0 || rs !== 1'b0) begin failures++; $display("FAIL word_rd lows/resp got %0d/%b want 0/0", lows, rs); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lows; logic rs;
    xfer(0, 32'h4, 3'd2, 1, 32'h0000_0000, rd, lows, rs);
    xfer(0, 32'h5, 3'd0, 1, 32'h0000_DD00, rd, lows, rs);
    xfer(0, 32'h6, 3'd1, 1, 32'hABCD_0000, rd, lows, rs);
    xfer(0, 32'h4, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'hABCD_DD00) begin failures++; $display("FAIL byte_lanes got %h want abcddd00", rd); end
    xfer(0, 32'h7, 3'd0, 1, 32'h1200_0000, rd, lows, rs);
    xfer(0, 32'h4, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'h12CD_DD00) begin failures++; $display("FAIL byte_lane3 got %h want 12cddd00", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int lows; logic rs;
    xfer(1, 32'h14, 3'd2, 1, 32'hCAFE_F00D, rd, lows, rs);
    checks++; if (lows !== 3) begin failures++; $display("FAIL wait_wr_lows got %0d want 3", lows); end
    xfer(1, 32'h14, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (lows !== 3) begin failures++; $display("FAIL wait_rd_lows got %0d want 3", lows); end
    checks++; if (rd !== 32'hCAFE_F00D || rs !== 1'b0) begin failures++; $display("FAIL wait_rd got %h/%b want cafef00d/0", rd, rs); end
  endtask

  task automatic test_back_to_back();
    int lows;
    tick();
    sel0 = 0; sel3 = 1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 1;
    tick();
    hwrite = 0; hwdata = 32'h1234_5678; lows = 0;
    while (!rdy3 && lows < 20) begin lows++; tick(); end
    checks++; if (lows !== 3) begin failures++; $display("FAIL b2b_wr_lows got %0d want 3", lows); end
    tick();
    htrans = 2'b00; lows = 0;
    while (!rdy3 && lows < 20) begin lows++; tick(); end
    checks++; if (lows !== 3) begin failures++; $display("FAIL b2b_rd_lows got %0d want 3", lows); end
    checks++; if (rdata3 !== 32'h1234_5678 || resp3 !== 1'b0) begin failures++; $display("FAIL b2b_rd got %h/%b want 12345678/0", rdata3, resp3); end
  endtask

  task automatic test_pipeline();
    int n_ready = 0;
    tick();
    sel0 = 1; sel3 = 0; hwrite = 1; hsize = 3'd2; htrans = 2'b10; haddr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy0) n_ready++;
      hwdata = pd[i];
      if (i < 3) haddr = 32'h24 + 32'(4 * i); else htrans = 2'b00;
    end
    checks++; if (n_ready !== 4) begin failures++; $display("FAIL pipe_ready got %0d want 4", n_ready); end
    tick();
    hwrite = 0; htrans = 2'b10; haddr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rdata0 !== pd[i] || rdy0 !== 1'b1) begin
        failures++; $display("FAIL pipe_rd%0d got %h/%b want %h/1", i, rdata0, rdy0, pd[i]);
      end
      if (i < 3) haddr = 32'h24 + 32'(4 * i); else htrans = 2'b00;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int lows; logic rs;
    xfer(1, 32'h30, 3'd2, 1, 32'h0000_0001, rd, lows, rs);
    tick();
    sel3 = 1; htrans = 2'b10; haddr = 32'h30; hsize = 3'd2; hwrite = 1;
    tick();
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL rst_wait1 got %b want 0", rdy3); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL rst_mid_rdy got %b want 1", rdy3); end
    tick();
    rst_n = 1'b1;
    xfer(1, 32'h30, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'h0000_0001 || lows !== 3) begin failures++; $display("FAIL rst_mid_rd got %h/%0d want 00000001/3", rd, lows); end
  endtask

  task automatic test_range();
    logic [31:0] rd; int lows; logic rs;
`ifdef AHB_SRAM_ERR_RESP_EN
    xfer(0, 32'h400, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rs !== 1'b1 || lows !== 1 || rd !== 32'd0) begin failures++; $display("FAIL err_oor got resp %b lows %0d data %h want 1/1/0", rs, lows, rd); end
    xfer(0, 32'h2, 3'd2, 1, 32'hDEAD_BEEF, rd, lows, rs);
    checks++; if (rs !== 1'b1 || lows !== 1) begin failures++; $display("FAIL err_misalign got resp %b lows %0d want 1/1", rs, lows); end
    xfer(0, 32'h0, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'h000D_EEEE || rs !== 1'b0) begin failures++; $display("FAIL err_nowrite got %h/%b want 000deeee/0", rd, rs); end
`else
    xfer(0, 32'h400, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'h000D_EEEE || rs !== 1'b0 || lows !== 0) begin failures++; $display("FAIL alias got %h/%b/%0d want 000deeee/0/0", rd, rs, lows); end
    xfer(0, 32'h2, 3'd2, 1, 32'h55AA_55AA, rd, lows, rs);
    checks++; if (rs !== 1'b0) begin failures++; $display("FAIL align_resp got %b want 0", rs); end
    xfer(0, 32'h0, 3'd2, 0, 32'h0, rd, lows, rs);
    checks++; if (rd !== 32'h55AA_55AA) begin failures++; $display("FAIL align_down got %h want 55aa55aa", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_wait_states();
    test_back_to_back();
    test_pipeline();
    test_reset_mid_wait();
    test_range();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
